// File: rtl/alu_accumulator_seq.sv
// alu_accumulator_seq
// Two-state sequencer that registers one command per handshake onto the
// ALU inputs, lets the combinational ALU settle for one cycle, then commits
// the result into a 32-bit accumulator. It also keeps sticky error flags and
// a count of completed commands.
module alu_accumulator_seq #(
    parameter int ACC_W = 32,
    parameter int OPD_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_opcode_i,
    input  logic [OPD_W-1:0] cmd_operand_i,
    output logic [OPD_W-1:0] alu_a_o,
    output logic [OPD_W-1:0] alu_b_o,
    output logic [3:0]       alu_opcode_o,
    input  logic [ACC_W-1:0] alu_result_i,
    input  logic [1:0]       alu_error_i,
    output logic [ACC_W-1:0] acc_o,
    output logic [1:0]       err_sticky_o,
    output logic             done_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'd12;
    localparam logic [3:0] OP_NOP    = 4'd13;
    localparam logic [3:0] OP_PRESET = 4'd14;
    localparam logic [3:0] OP_CLEAR  = 4'd15;

    state_t           state_q;
    logic             ready_q;
    logic [OPD_W-1:0] alu_a_q;
    logic [OPD_W-1:0] alu_b_q;
    logic [3:0]       alu_opcode_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [1:0]       err_q;
    logic [1:0]       err_d;
    logic [1:0]       err_mask;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    // Which ALU error bits actually mean something for the latched opcode:
    // overflow only for add/sub, divide-by-zero only for div/mod.
    always_comb begin
        err_mask = 2'b00;
        case (alu_opcode_q)
            4'd0, 4'd1: err_mask = 2'b01;
            4'd3, 4'd4: err_mask = 2'b10;
            default:    err_mask = 2'b00;
        endcase
    end

    // Commit value for the accumulator and sticky flags at the end of EXEC.
    always_comb begin
        acc_d = acc_q;
        err_d = err_q;
        if (alu_opcode_q <= 4'd11) begin
            // A divide-by-zero result is garbage, so the accumulator keeps
            // its old value; the flag still gets recorded.
            if (!alu_error_i[1]) begin
                acc_d = alu_result_i;
            end
            err_d = err_q | (alu_error_i & err_mask);
        end else begin
            case (alu_opcode_q)
                OP_LOAD:   acc_d = {{(ACC_W-OPD_W){1'b0}}, alu_b_q};
                OP_NOP:    acc_d = acc_q;
                OP_PRESET: acc_d = {ACC_W{1'b1}};
                OP_CLEAR: begin
                    acc_d = '0;
                    err_d = 2'b00;
                end
                default:   acc_d = acc_q;
            endcase
        end
    end

    // Sequencer: accept in IDLE, commit in EXEC; all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= OP_NOP;
            acc_q        <= '0;
            err_q        <= 2'b00;
            done_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid_i && ready_q) begin
                        // Operand A is fed back from the low half only.
                        alu_a_q      <= acc_q[OPD_W-1:0];
                        alu_b_q      <= cmd_operand_i;
                        alu_opcode_q <= cmd_opcode_i;
                        ready_q      <= 1'b0;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q   <= acc_d;
                    err_q   <= err_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = ready_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_opcode_q;
    assign acc_o        = acc_q;
    assign err_sticky_o = err_q;
    assign done_o       = done_q;
    assign op_count_o   = cnt_q;

endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Directed bench for alu_accumulator_seq with a behavioural 16-bit ALU
// closing the loop from alu_* outputs back to alu_result/alu_error.
module tb_alu_accumulator_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [3:0]  cmd_opcode_i = 4'd13;
    logic [15:0] cmd_operand_i = 16'd0;
    logic [15:0] alu_a_o;
    logic [15:0] alu_b_o;
    logic [3:0]  alu_opcode_o;
    logic [31:0] alu_result_i;
    logic [1:0]  alu_error_i;
    logic [31:0] acc_o;
    logic [1:0]  err_sticky_o;
    logic        done_o;
    logic [7:0]  op_count_o;

    logic [1:0]  inj_err = 2'b00;
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    alu_accumulator_seq #(.ACC_W(32), .OPD_W(16), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i), .cmd_operand_i(cmd_operand_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
        .alu_result_i(alu_result_i), .alu_error_i(alu_error_i),
        .acc_o(acc_o), .err_sticky_o(err_sticky_o), .done_o(done_o),
        .op_count_o(op_count_o)
    );

    // Behavioural ALU; inj_err lets a test raise error bits an opcode
    // would not normally produce.
    logic [15:0] sum16;
    logic [15:0] dif16;
    always_comb begin
        sum16 = alu_a_o + alu_b_o;
        dif16 = alu_a_o - alu_b_o;
        alu_result_i = 32'd0;
        alu_error_i  = 2'b00;
        case (alu_opcode_o)
            4'd0: begin
                alu_result_i = {16'd0, sum16};
                alu_error_i[0] = (alu_a_o[15] == alu_b_o[15]) && (sum16[15] != alu_a_o[15]);
            end
            4'd1: begin
                alu_result_i = {16'd0, dif16};
                alu_error_i[0] = (alu_a_o[15] != alu_b_o[15]) && (dif16[15] != alu_a_o[15]);
            end
            4'd2: alu_result_i = {16'd0, alu_a_o} * {16'd0, alu_b_o};
            4'd3: if (alu_b_o == 16'd0) alu_error_i[1] = 1'b1;
                  else alu_result_i = {16'd0, alu_a_o / alu_b_o};
            4'd4: if (alu_b_o == 16'd0) alu_error_i[1] = 1'b1;
                  else alu_result_i = {16'd0, alu_a_o % alu_b_o};
            4'd5: alu_result_i = {16'd0, alu_a_o & alu_b_o};
            4'd6: alu_result_i = {16'd0, alu_a_o | alu_b_o};
            4'd7: alu_result_i = {16'd0, alu_a_o ^ alu_b_o};
            default: alu_result_i = 32'd0;
        endcase
        alu_error_i = alu_error_i | inj_err;
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0;
        inj_err = 2'b00;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Present a command and wait (bounded) for acceptance; returns at the
    // falling edge after the accept edge with valid dropped.
    task automatic issue_cmd(input logic [3:0] op, input logic [15:0] opd);
        int w;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_opcode_i = op;
        cmd_operand_i = opd;
        w = 0;
        while (!cmd_ready_o && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        total++;
        if (!cmd_ready_o) begin
            bad++;
            $display("FAIL accept_timeout op=%0d ready=%b required=1", op, cmd_ready_o);
            cmd_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
        end
    endtask

    // Advance to just after the commit edge.
    task automatic finish_cmd();
        @(posedge clk_i);
        #1;
        $display("cmd op=%0d b=%h -> acc=%h err=%b done=%b cnt=%0d",
                 alu_opcode_o, alu_b_o, acc_o, err_sticky_o, done_o, op_count_o);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [15:0] opd);
        issue_cmd(op, opd);
        finish_cmd();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_opcode_i = 4'd12;
        cmd_operand_i = 16'd7;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready_o); end
        total++; if (acc_o !== 32'd0) begin bad++; $display("FAIL rst_acc got=%h exp=0", acc_o); end
        total++; if (err_sticky_o !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", err_sticky_o); end
        total++; if (op_count_o !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", op_count_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_o); end
        total++; if (alu_opcode_o !== 4'd13 || alu_b_o !== 16'd0 || alu_a_o !== 16'd0)
            begin bad++; $display("FAIL rst_alu got=%h/%h/%h exp=d/0/0", alu_opcode_o, alu_a_o, alu_b_o); end
        // Release with valid still high: the first edge must accept.
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        total++; if (cmd_ready_o !== 1'b0 || alu_b_o !== 16'd7 || alu_opcode_o !== 4'd12)
            begin bad++; $display("FAIL first_accept got rdy=%b b=%h op=%h exp=0/0007/c", cmd_ready_o, alu_b_o, alu_opcode_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        finish_cmd();
        total++; if (acc_o !== 32'd7 || done_o !== 1'b1 || op_count_o !== 8'd1)
            begin bad++; $display("FAIL first_load got acc=%h done=%b cnt=%0d exp=7/1/1", acc_o, done_o, op_count_o); end
        @(posedge clk_i);
        #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL done_single got=%b exp=0", done_o); end
    endtask

    task automatic test_chain();
        do_reset();
        run_cmd(4'd12, 16'd15);
        total++; if (acc_o !== 32'd15 || done_o !== 1'b1) begin bad++; $display("FAIL chain_load got acc=%0d done=%b exp=15/1", acc_o, done_o); end
        issue_cmd(4'd0, 16'd126);
        total++; if (alu_a_o !== 16'd15) begin bad++; $display("FAIL chain_feedback got=%0d exp=15", alu_a_o); end
        finish_cmd();
        total++; if (acc_o !== 32'd141 || done_o !== 1'b1) begin bad++; $display("FAIL chain_add got acc=%0d done=%b exp=141/1", acc_o, done_o); end
        run_cmd(4'd2, 16'd3);
        total++; if (acc_o !== 32'd423 || err_sticky_o !== 2'b00) begin bad++; $display("FAIL chain_mul got acc=%0d err=%b exp=423/00", acc_o, err_sticky_o); end
        total++; if (op_count_o !== 8'd3) begin bad++; $display("FAIL chain_cnt got=%0d exp=3", op_count_o); end
    endtask

    task automatic test_div_zero();
        run_cmd(4'd3, 16'd0);
        total++; if (acc_o !== 32'd423) begin bad++; $display("FAIL div0_acc got=%0d exp=423", acc_o); end
        total++; if (err_sticky_o !== 2'b10) begin bad++; $display("FAIL div0_err got=%b exp=10", err_sticky_o); end
        run_cmd(4'd15, 16'd0);
        total++; if (acc_o !== 32'd0 || err_sticky_o !== 2'b00) begin bad++; $display("FAIL clear got acc=%h err=%b exp=0/00", acc_o, err_sticky_o); end
    endtask

    task automatic test_error_mask();
        do_reset();
        run_cmd(4'd12, 16'h7FFF);
        run_cmd(4'd0, 16'd1);
        total++; if (acc_o !== 32'h0000_8000 || err_sticky_o !== 2'b01)
            begin bad++; $display("FAIL ovf got acc=%h err=%b exp=00008000/01", acc_o, err_sticky_o); end
        run_cmd(4'd15, 16'd0);
        run_cmd(4'd12, 16'd2);
        inj_err = 2'b01;
        run_cmd(4'd2, 16'd3);
        total++; if (acc_o !== 32'd6 || err_sticky_o !== 2'b00)
            begin bad++; $display("FAIL mask_mul got acc=%0d err=%b exp=6/00", acc_o, err_sticky_o); end
        run_cmd(4'd3, 16'd2);
        total++; if (acc_o !== 32'd3 || err_sticky_o !== 2'b00)
            begin bad++; $display("FAIL mask_div got acc=%0d err=%b exp=3/00", acc_o, err_sticky_o); end
        inj_err = 2'b00;
        run_cmd(4'd12, 16'd9);
        total++; if (acc_o !== 32'd9 || err_sticky_o !== 2'b00)
            begin bad++; $display("FAIL load_noerr got acc=%0d err=%b exp=9/00", acc_o, err_sticky_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3];
        logic [15:0] opds [3];
        int idx, cyc, last;
        logic rdy;
        ops[0] = 4'd12; opds[0] = 16'd1;
        ops[1] = 4'd0;  opds[1] = 16'd2;
        ops[2] = 4'd0;  opds[2] = 16'd4;
        do_reset();
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_opcode_i = ops[0];
        cmd_operand_i = opds[0];
        idx = 0; cyc = 0; last = 0;
        while (idx < 3 && cyc < 20) begin
            rdy = cmd_ready_o;
            @(posedge clk_i);
            cyc++;
            if (rdy) begin
                if (idx > 0) begin
                    total++;
                    if (cyc - last !== 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=2", cyc - last); end
                end
                last = cyc;
                idx++;
            end
            @(negedge clk_i);
            if (idx < 3) begin
                cmd_opcode_i = ops[idx];
                cmd_operand_i = opds[idx];
            end else begin
                cmd_valid_i = 1'b0;
            end
            if (rdy) begin
                total++;
                if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_exec_ready got=%b exp=0", cmd_ready_o); end
            end
        end
        cmd_valid_i = 1'b0;
        total++; if (idx !== 3) begin bad++; $display("FAIL b2b_timeout accepted=%0d exp=3", idx); end
        finish_cmd();
        total++; if (acc_o !== 32'd7 || op_count_o !== 8'd3)
            begin bad++; $display("FAIL b2b_result got acc=%0d cnt=%0d exp=7/3", acc_o, op_count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_cmd(4'd12, 16'd10);
        issue_cmd(4'd0, 16'd5);
        rst_ni = 1'b0;
        #1;
        total++; if (acc_o !== 32'd0 || done_o !== 1'b0 || cmd_ready_o !== 1'b1)
            begin bad++; $display("FAIL midrst_async got acc=%0d done=%b rdy=%b exp=0/0/1", acc_o, done_o, cmd_ready_o); end
        @(posedge clk_i);
        #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        total++; if (done_o !== 1'b0 || acc_o !== 32'd0 || cmd_ready_o !== 1'b1 || op_count_o !== 8'd0)
            begin bad++; $display("FAIL midrst_after got done=%b acc=%0d rdy=%b cnt=%0d exp=0/0/1/0", done_o, acc_o, cmd_ready_o, op_count_o); end
    endtask

    task automatic test_wrap_preset();
        do_reset();
        for (int i = 0; i < 255; i++) run_cmd(4'd13, 16'd0);
        total++; if (op_count_o !== 8'd255) begin bad++; $display("FAIL cnt_255 got=%0d exp=255", op_count_o); end
        run_cmd(4'd13, 16'd0);
        total++; if (op_count_o !== 8'd0 || acc_o !== 32'd0) begin bad++; $display("FAIL cnt_wrap got cnt=%0d acc=%h exp=0/0", op_count_o, acc_o); end
        run_cmd(4'd14, 16'd0);
        total++; if (acc_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL preset got=%h exp=ffffffff", acc_o); end
        issue_cmd(4'd0, 16'd0);
        total++; if (alu_a_o !== 16'hFFFF) begin bad++; $display("FAIL preset_feedback got=%h exp=ffff", alu_a_o); end
        finish_cmd();
        total++; if (acc_o !== 32'h0000_FFFF || err_sticky_o !== 2'b00)
            begin bad++; $display("FAIL trunc_add got acc=%h err=%b exp=0000ffff/00", acc_o, err_sticky_o); end
    endtask

    // done must never be high on two consecutive rising edges.
    logic done_prev = 1'b0;
    always @(posedge clk_i) begin
        if (done_o && done_prev) begin
            bad++;
            $display("FAIL done_double got=1 exp=0");
        end
        done_prev <= done_o;
    end

    initial begin
        test_reset();
        test_chain();
        test_div_zero();
        test_error_mask();
        test_back_to_back();
        test_reset_mid();
        test_wrap_preset();
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_accumulator_seq.md
# alu_accumulator_seq

Sequencing and accumulator stage that sits directly downstream of the 16-bit BreadBoard ALU and feeds its operand A back from the accumulator. It accepts one command per valid/ready handshake, drives the ALU opcode and operands from registers, and waits one settle cycle. It then captures the 32-bit ALU result into the accumulator, or blocks the capture on error, and tracks sticky error flags and a completed-operation count.

## Interface
- ACC_W, 32, accumulator / ALU result width
- OPD_W, 16, operand width (ALU input width)
- CNT_W, 8, completed-operation counter width

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_opcode  in  4  operation (ALU opcode map: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-11 logic, 12 load, 13 nop, 14 preset, 15 clear)
- cmd_operand  in  OPD_W  operand B / load value
- alu_a  out  OPD_W  to ALU inputA, = registered acc[15:0]
- alu_b  out  OPD_W  to ALU inputB, registered operand
- alu_opcode  out  4  to ALU OpCode, registered
- alu_result  in  ACC_W  from ALU Result (combinational)
- alu_error  in  2  from ALU Error ([0] add/sub overflow, [1] div/mod by zero)
- acc  out  ACC_W  accumulator
- err_sticky  out  2  sticky OR of captured alu_error bits
- done  out  1  one-cycle pulse, command completed
- op_count  out  CNT_W  completed commands, wraps

## Operation
- States: IDLE, EXEC. Reset enters IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register alu_a<=acc[15:0], alu_b<=cmd_operand, alu_opcode<=cmd_opcode, then go to EXEC.
  - With no handshake, alu_* registers hold.
- EXEC: cmd_ready=0. At the next edge, apply the commit rule per latched opcode, pulse done, increment op_count, and return to IDLE.
- Commit rules:
  - 0-11 (ALU ops):
    - If alu_error[1]=1, acc is unchanged.
    - Otherwise acc<=alu_result.
    - In both cases err_sticky<=err_sticky|alu_error.
  - 12 (load): acc<={16'b0, alu_b}. ALU result ignored; err_sticky unchanged.
  - 13 (nop): acc and err_sticky unchanged.
  - 14 (preset): acc<=all ones. ALU result ignored.
  - 15 (clear): acc<=0 and err_sticky<=0. ALU result ignored.
- Only alu_error bits meaningful for the opcode are ORed: bit0 for opcodes 0-1, bit1 for opcodes 3-4. For all other opcodes, no error bits are ORed.
- Feedback is truncated: alu_a takes acc[15:0] only, and upper accumulator bits are dropped as operand.
- op_count increments on every completion, including nop, load and errored ops. It wraps from 2^CNT_W-1 to 0.
- cmd_valid is ignored while in EXEC. A source holding valid is accepted on the next IDLE cycle.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, cmd_ready=1
  - acc=0, err_sticky=0, op_count=0, done=0
  - alu_a=0, alu_b=0, alu_opcode=4'b1101 (nop)
- Reset release is synchronous to clk; the first handshake is possible on the first edge after release.
- Handshake at edge N:
  - alu_* valid after N.
  - ALU settles combinationally during cycle N..N+1.
  - acc/err_sticky/op_count update at edge N+1.
  - done=1 for cycle N+1..N+2 only.
  - cmd_ready returns to 1 after N+1.
- Throughput is one command per 2 cycles; back-to-back accepts occur at edges N and N+2.
- The second command sees the updated acc, because alu_a is registered at N+2 from acc written at N+1.
- Reset asserted mid-EXEC aborts the command immediately: no acc write and no done pulse.
- done is registered. It is never high during reset and never high on two consecutive cycles.

## Test plan
- Reset: hold reset=0 with cmd_valid=1 → cmd_ready=1, acc=0, err_sticky=0, op_count=0, done=0; no handshake occurs while in reset; after release, first accept on first edge.
- Chain with real ALU: load 15, add 126, mul 3 → acc=15, then 141, then 423; done pulses at edges 2, 4, 6 after first accept; op_count=3.
- Divide by zero: acc=423, div operand 0 → acc stays 423, err_sticky=2'b10; next op clear → acc=0, err_sticky=2'b00.
- Backpressure: cmd_valid held high for 3 distinct commands → accepts only on alternate edges, cmd_ready=0 in EXEC, no command lost or duplicated, op_count=3.
- Reset mid-operation: accept add 5 with acc=10, assert reset=0 during EXEC → acc=0, no done, state IDLE after release.
- Wrap and preset: 256 nops → op_count wraps to 0; preset → acc=32'hFFFFFFFF, alu_a next command=16'hFFFF.
